pulse_f2s_req: RTL and testbench

Fast-domain request side of a four-phase handshake that carries single-cycle pulses from the fast clock domain into a slower one. The receiver is a slow-domain synchroniser that edge-detects `req` and returns `ack`. The block converts each `din` pulse into a `req` level held until `ack` is seen. Pulses arriving mid-handshake are queued in a saturating pending counter, so fast-domain events are neither shortened below the slow clock period nor silently lost.

---
 rtl/cdc_pkg.sv | 11 +
 rtl/sync_bit.sv | 18 +
 rtl/pulse_f2s_req.sv | 86 ++++++++
 tb/tb_pulse_f2s_req.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/cdc_pkg.sv
// Shared definitions for the pulse clock-domain-crossing handshake blocks.
package cdc_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_REL  = 2'd2
  } state_t;

  localparam int SYNC_MIN = 2;
  localparam int SYNC_MAX = 4;
endpackage

// File: rtl/sync_bit.sv
// N-stage single-bit synchroniser; also used by the slow-side receiver.
module sync_bit #(
  parameter int N = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [N-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[N-2:0], d};
  end

  assign q = ff[N-1];
endmodule

// File: rtl/pulse_f2s_req.sv
// Fast-side requester: turns din pulses into four-phase req levels, queueing
// events that arrive mid-handshake in a saturating pending counter.
module pulse_f2s_req
  import cdc_pkg::*;
#(
  parameter int CNT_W       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clkb,
  input  logic             rst_n,
  input  logic             din,
  input  logic             ack,
  output logic             req,
  output logic             busy,
  output logic             sent,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             overflow
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  generate
    if (SYNC_STAGES < SYNC_MIN || SYNC_STAGES > SYNC_MAX) begin : g_bad_sync
      $error("pulse_f2s_req: SYNC_STAGES out of range");
    end
  endgenerate

  state_t state;
  logic   ack_s;
  logic   start;
  logic   queue;

  sync_bit #(.N(SYNC_STAGES)) u_ack_sync (
    .clk   (clkb),
    .rst_n (rst_n),
    .d     (ack),
    .q     (ack_s)
  );

  // A stale ack_s blocks a new request until the receiver has released.
  always_comb begin
    start = (state == ST_IDLE) && !ack_s && (din || (pend_cnt != '0));
    queue = din && !start;
  end

  always_ff @(posedge clkb or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      req      <= 1'b0;
      busy     <= 1'b0;
      sent     <= 1'b0;
      overflow <= 1'b0;
      pend_cnt <= '0;
    end else begin
      sent     <= 1'b0;
      overflow <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          state <= ST_REQ;
          req   <= 1'b1;
          busy  <= 1'b1;
        end
        ST_REQ: if (ack_s) begin
          state <= ST_REL;
          req   <= 1'b0;
          sent  <= 1'b1;
        end
        ST_REL: if (!ack_s) begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          req   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase

      // start without din implies pend_cnt > 0, so no underflow here.
      if (start && !din)  pend_cnt <= pend_cnt - ONE;
      else if (queue) begin
        if (&pend_cnt) overflow <= 1'b1;
        else           pend_cnt <= pend_cnt + ONE;
      end
    end
  end
endmodule

// File: tb/tb_pulse_f2s_req.sv
// Directed bench for pulse_f2s_req: cycle table plus handshake corner sequences.
module tb_pulse_f2s_req;
  logic       clkb = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic       ack_man = 1'b0;
  logic       ack_m;
  logic       rx_auto = 1'b0;
  logic       ack;
  logic       req, busy, sent, overflow;
  logic [1:0] pend_cnt;

  logic       din3 = 1'b0;
  logic       ack3 = 1'b0;
  logic       req3, busy3, sent3, ovf3;
  logic [3:0] pend3;

  logic [5:0] obs;
  int n_cmp = 0;
  int n_bad = 0;
  int sent_n = 0, ovf_n = 0, rise_n = 0;
  logic req_d = 1'b0;
  int rcnt;

  typedef struct {
    logic       din;
    logic       ack;
    logic [5:0] exp;   // {req, busy, sent, overflow, pend_cnt}
  } vec_t;
  vec_t tbl[13];

  always #5 clkb = ~clkb;

  assign ack = rx_auto ? ack_m : ack_man;
  assign obs = {req, busy, sent, overflow, pend_cnt};

  pulse_f2s_req #(.CNT_W(2), .SYNC_STAGES(2)) dut (
    .clkb(clkb), .rst_n(rst_n), .din(din), .ack(ack), .req(req), .busy(busy),
    .sent(sent), .pend_cnt(pend_cnt), .overflow(overflow)
  );

  pulse_f2s_req #(.CNT_W(4), .SYNC_STAGES(3)) dut3 (
    .clkb(clkb), .rst_n(rst_n), .din(din3), .ack(ack3), .req(req3), .busy(busy3),
    .sent(sent3), .pend_cnt(pend3), .overflow(ovf3)
  );

  // Receiver model: follows req with ack five cycles after each req change.
  always @(posedge clkb or negedge rst_n) begin
    if (!rst_n) begin
      ack_m <= 1'b0;
      rcnt  <= 0;
    end else if (req != ack_m) begin
      if (rcnt == 4) begin ack_m <= req; rcnt <= 0; end
      else rcnt <= rcnt + 1;
    end else rcnt <= 0;
  end

  always @(negedge clkb) begin
    req_d <= req;
    if (sent)          sent_n <= sent_n + 1;
    if (overflow)      ovf_n  <= ovf_n + 1;
    if (req && !req_d) rise_n <= rise_n + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic d, input logic a);
    @(negedge clkb);
    din = d;
    ack_man = a;
    @(posedge clkb);
    #1;
  endtask

  task automatic reset_dut();
    @(negedge clkb);
    rst_n = 1'b0;
    din = 1'b0; ack_man = 1'b0; din3 = 1'b0; ack3 = 1'b0;
    repeat (2) @(negedge clkb);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (!busy && pend_cnt == 2'd0) begin ok = 1'b1; break; end
      step(1'b0, 1'b0);
    end
    chk(name, {31'd0, ok}, 32'd1);
  endtask

  initial begin
    int s0, o0, r0, n;

    tbl[0]  = '{1'b0, 1'b0, 6'b000000};
    tbl[1]  = '{1'b1, 1'b0, 6'b110000};
    tbl[2]  = '{1'b1, 1'b0, 6'b110001};
    tbl[3]  = '{1'b1, 1'b1, 6'b110010};
    tbl[4]  = '{1'b1, 1'b1, 6'b110011};
    tbl[5]  = '{1'b1, 1'b1, 6'b011111};
    tbl[6]  = '{1'b0, 1'b0, 6'b010011};
    tbl[7]  = '{1'b0, 1'b0, 6'b010011};
    tbl[8]  = '{1'b0, 1'b0, 6'b000011};
    tbl[9]  = '{1'b0, 1'b0, 6'b110010};
    tbl[10] = '{1'b1, 1'b0, 6'b110011};
    tbl[11] = '{1'b1, 1'b0, 6'b110111};
    tbl[12] = '{1'b0, 1'b0, 6'b110011};

    repeat (2) @(negedge clkb);
    #1;
    chk("reset_state", {26'd0, obs}, 32'd0);
    chk("reset_state3", {24'd0, req3, busy3, sent3, ovf3, pend3}, 32'd0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].din, tbl[i].ack);
      chk($sformatf("table_row%0d", i), {26'd0, obs}, {26'd0, tbl[i].exp});
    end

    // din on the same edge IDLE would consume a queued event
    reset_dut();
    repeat (3) step(1'b1, 1'b0);
    chk("simul_fill", {26'd0, obs}, {26'd0, 6'b110010});
    repeat (3) step(1'b0, 1'b1);
    chk("simul_rel", {26'd0, obs}, {26'd0, 6'b011010});
    repeat (3) step(1'b0, 1'b0);
    chk("simul_idle", {26'd0, obs}, {26'd0, 6'b000010});
    step(1'b1, 1'b0);
    chk("simul_start", {26'd0, obs}, {26'd0, 6'b110010});

    // asynchronous reset mid-REQ with ack still high
    reset_dut();
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    chk("pre_reset", {26'd0, obs}, {26'd0, 6'b110001});
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {26'd0, obs}, 32'd0);
    @(negedge clkb);
    rst_n = 1'b1;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    chk("stale_ack_queue", {26'd0, obs}, {26'd0, 6'b000001});
    step(1'b0, 1'b1);
    chk("stale_ack_hold", {26'd0, obs}, {26'd0, 6'b000001});
    step(1'b0, 1'b0);
    chk("ack_drop_1", {31'd0, req}, 32'd0);
    step(1'b0, 1'b0);
    chk("ack_drop_2", {31'd0, req}, 32'd0);
    step(1'b0, 1'b0);
    chk("ack_clear_req", {26'd0, obs}, {26'd0, 6'b110000});

    // three-stage synchroniser: ack rise to req fall
    reset_dut();
    @(negedge clkb); din3 = 1'b1;
    @(posedge clkb); #1;
    chk("s3_req_rise", {31'd0, req3}, 32'd1);
    @(negedge clkb); din3 = 1'b0; ack3 = 1'b1;
    n = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clkb); #1;
      n++;
      if (!req3) break;
    end
    chk("s3_ack_to_req_fall", n, 32'd4);
    ack3 = 1'b0;

    // automatic receiver sequences
    reset_dut();
    rx_auto = 1'b1;
    s0 = sent_n; o0 = ovf_n; r0 = rise_n;
    step(1'b1, 1'b0);
    chk("single_req_rise", {26'd0, obs}, {26'd0, 6'b110000});
    step(1'b0, 1'b0);
    wait_idle("single_idle");
    chk("single_sent", sent_n - s0, 32'd1);
    chk("single_rises", rise_n - r0, 32'd1);

    s0 = sent_n; o0 = ovf_n; r0 = rise_n;
    repeat (3) step(1'b1, 1'b0);
    chk("burst_pend", {30'd0, pend_cnt}, 32'd2);
    step(1'b0, 1'b0);
    wait_idle("burst_idle");
    chk("burst_sent", sent_n - s0, 32'd3);
    chk("burst_rises", rise_n - r0, 32'd3);
    chk("burst_ovf", ovf_n - o0, 32'd0);

    s0 = sent_n; o0 = ovf_n; r0 = rise_n;
    step(1'b1, 1'b0);
    repeat (5) step(1'b1, 1'b0);
    chk("sat_pend", {29'd0, req, pend_cnt}, 32'd7);
    step(1'b0, 1'b0);
    wait_idle("sat_idle");
    chk("sat_ovf", ovf_n - o0, 32'd2);
    chk("sat_sent", sent_n - s0, 32'd4);
    chk("sat_rises", rise_n - r0, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
